// File: rtl/siggen_pkg.sv
// Shared types and defaults for the signal-generator run sequencer.
package siggen_pkg;

   localparam int SEQ_ADDR_WIDTH  = 9;
   localparam int SEQ_DIV_WIDTH   = 16;
   localparam int SEQ_BURST_WIDTH = 8;

   localparam int DEF_DIV    = 0;
   localparam int DEF_INCR   = 1;
   localparam int DEF_BURSTS = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic [SEQ_DIV_WIDTH-1:0]   div;
      logic [SEQ_ADDR_WIDTH-1:0]  incr;
      logic [SEQ_BURST_WIDTH-1:0] bursts;
   } seq_cfg_t;

endpackage

// File: rtl/siggen_seq_ctrl_if.sv
// Configuration valid/ready bus between the control front end and the sequencer.
interface siggen_seq_ctrl_if
   import siggen_pkg::*;
#(
   parameter int ADDR_WIDTH  = SEQ_ADDR_WIDTH,
   parameter int DIV_WIDTH   = SEQ_DIV_WIDTH,
   parameter int BURST_WIDTH = SEQ_BURST_WIDTH
);

   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [DIV_WIDTH-1:0]   cfg_div;
   logic [ADDR_WIDTH-1:0]  cfg_incr;
   logic [BURST_WIDTH-1:0] cfg_bursts;

   modport master (output cfg_valid, output cfg_div, output cfg_incr, output cfg_bursts,
                   input cfg_ready);
   modport slave  (input cfg_valid, input cfg_div, input cfg_incr, input cfg_bursts,
                   output cfg_ready);

endinterface

// File: rtl/siggen_prescaler.sv
// Step prescaler: counts 0..div and presents a registered tick for the cycle the count hits div.
module siggen_prescaler
   import siggen_pkg::*;
#(
   parameter int DIV_WIDTH = SEQ_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 adv,
   input  logic                 run_nxt,
   input  logic [DIV_WIDTH-1:0] div_nxt,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 tick_q, tick_d;

   // The tick is looked ahead one cycle so it can leave a flop; div_nxt is the divider
   // that will be active next cycle, which matters when a new divider lands on a wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {DIV_WIDTH{1'b0}};
      end else if (adv) begin
         cnt_d = tick_q ? {DIV_WIDTH{1'b0}} : cnt_q + DIV_WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
      tick_d = run_nxt & (cnt_d == div_nxt);
   end

   // Prescaler state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= {DIV_WIDTH{1'b0}};
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/siggen_seq_ctrl.sv
// Run sequencer for the waveform address counter: clear, step enable and increment,
// with configuration changes deferred to the counter's wrap so frequency steps are glitch-free.
module siggen_seq_ctrl
   import siggen_pkg::*;
#(
   parameter int ADDR_WIDTH  = SEQ_ADDR_WIDTH,
   parameter int DIV_WIDTH   = SEQ_DIV_WIDTH,
   parameter int BURST_WIDTH = SEQ_BURST_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   siggen_seq_ctrl_if.slave      cfg_if,
   input  logic                  start,
   input  logic                  stop,
   input  logic [ADDR_WIDTH-1:0] cnt_count,
   output logic                  cnt_rst,
   output logic                  cnt_en,
   output logic [ADDR_WIDTH-1:0] cnt_incr,
   output logic                  busy,
   output logic                  done
);

   seq_state_t             state_q, state_d;
   logic [DIV_WIDTH-1:0]   act_div_q, act_div_d, pend_div_q, pend_div_d;
   logic [ADDR_WIDTH-1:0]  act_incr_q, act_incr_d, pend_incr_q, pend_incr_d;
   logic [BURST_WIDTH-1:0] act_bursts_q, act_bursts_d, pend_bursts_q, pend_bursts_d;
   logic [BURST_WIDTH-1:0] period_q, period_d;
   logic                   pend_valid_q, pend_valid_d;
   logic                   stop_pend_q, stop_pend_d;
   logic                   cnt_rst_q, cnt_rst_d;
   logic                   done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   cfg_ready_q, cfg_ready_d;

   logic                   tick;
   logic                   cfg_fire;
   logic                   wrap;
   logic                   finish;
   logic [ADDR_WIDTH:0]    incr_sum;

   siggen_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == CLEAR),
      .adv     (state_q == RUN),
      .run_nxt (state_d == RUN),
      .div_nxt (act_div_d),
      .tick    (tick)
   );

   // Next-state, shadow-register and registered-output logic.
   always_comb begin
      state_d       = state_q;
      act_div_d     = act_div_q;
      act_incr_d    = act_incr_q;
      act_bursts_d  = act_bursts_q;
      pend_div_d    = pend_div_q;
      pend_incr_d   = pend_incr_q;
      pend_bursts_d = pend_bursts_q;
      pend_valid_d  = pend_valid_q;
      period_d      = period_q;
      stop_pend_d   = stop_pend_q;

      // A wrap is the step whose sum carries out of the counter width.
      incr_sum = {1'b0, cnt_count} + {1'b0, act_incr_q};
      cfg_fire = cfg_if.cfg_valid & cfg_ready_q;
      wrap     = tick & incr_sum[ADDR_WIDTH];
      finish   = stop_pend_q |
                 ((act_bursts_q != BURST_WIDTH'(0)) & (period_q == act_bursts_q - BURST_WIDTH'(1)));

      case (state_q)
         IDLE: begin
            if (cfg_fire) begin
               act_div_d    = cfg_if.cfg_div;
               act_incr_d   = cfg_if.cfg_incr;
               act_bursts_d = cfg_if.cfg_bursts;
            end else begin
               act_div_d    = act_div_q;
            end
            state_d = start ? CLEAR : IDLE;
         end
         CLEAR: begin
            period_d    = BURST_WIDTH'(0);
            stop_pend_d = stop;
            state_d     = RUN;
         end
         RUN: begin
            stop_pend_d = stop_pend_q | stop;
            if (cfg_fire) begin
               pend_div_d    = cfg_if.cfg_div;
               pend_incr_d   = cfg_if.cfg_incr;
               pend_bursts_d = cfg_if.cfg_bursts;
               pend_valid_d  = 1'b1;
            end else begin
               pend_valid_d  = pend_valid_q;
            end
            if (wrap) begin
               period_d = period_q + BURST_WIDTH'(1);
               if (pend_valid_q) begin
                  act_div_d    = pend_div_q;
                  act_incr_d   = pend_incr_q;
                  act_bursts_d = pend_bursts_q;
                  pend_valid_d = 1'b0;
                  period_d     = BURST_WIDTH'(0);
               end else begin
                  act_div_d    = act_div_q;
               end
               state_d = finish ? FINISH : RUN;
            end else begin
               state_d = RUN;
            end
         end
         FINISH: begin
            // A config accepted on the final wrap is still honoured for the next run.
            if (pend_valid_q) begin
               act_div_d    = pend_div_q;
               act_incr_d   = pend_incr_q;
               act_bursts_d = pend_bursts_q;
               pend_valid_d = 1'b0;
            end else begin
               pend_valid_d = 1'b0;
            end
            stop_pend_d = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cnt_rst_d   = (state_d == CLEAR);
      done_d      = (state_d == FINISH);
      busy_d      = (state_d != IDLE);
      cfg_ready_d = (state_d == IDLE) | ((state_d == RUN) & ~pend_valid_d);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         act_div_q     <= DIV_WIDTH'(DEF_DIV);
         act_incr_q    <= ADDR_WIDTH'(DEF_INCR);
         act_bursts_q  <= BURST_WIDTH'(DEF_BURSTS);
         pend_div_q    <= {DIV_WIDTH{1'b0}};
         pend_incr_q   <= {ADDR_WIDTH{1'b0}};
         pend_bursts_q <= {BURST_WIDTH{1'b0}};
         pend_valid_q  <= 1'b0;
         period_q      <= {BURST_WIDTH{1'b0}};
         stop_pend_q   <= 1'b0;
         cnt_rst_q     <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         cfg_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         act_div_q     <= act_div_d;
         act_incr_q    <= act_incr_d;
         act_bursts_q  <= act_bursts_d;
         pend_div_q    <= pend_div_d;
         pend_incr_q   <= pend_incr_d;
         pend_bursts_q <= pend_bursts_d;
         pend_valid_q  <= pend_valid_d;
         period_q      <= period_d;
         stop_pend_q   <= stop_pend_d;
         cnt_rst_q     <= cnt_rst_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         cfg_ready_q   <= cfg_ready_d;
      end
   end

   assign cnt_rst          = cnt_rst_q;
   assign cnt_en           = tick;
   assign cnt_incr         = act_incr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign cfg_if.cfg_ready = cfg_ready_q;

endmodule

// File: doc/siggen_seq_ctrl.md
Name: siggen_seq_ctrl

Overview:
Sequencer for the signal-generator phase/address counter. It generates the counter's enable, synchronous clear and increment from a programmable clock prescaler. It runs continuous or N-period bursts and accepts new configuration through a valid/ready handshake. Configuration changes take effect only on a waveform period boundary, so output frequency changes are glitch-free. It sits between the register/control front end and the address counter that feeds the waveform ROM.

Parameters:
ADDR_WIDTH, 9, width of the controlled address counter and of the increment
DIV_WIDTH, 16, prescaler width; step period is cfg_div+1 clk cycles
BURST_WIDTH, 8, period-count width; 0 means run continuously

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration can be accepted
cfg_div  in  DIV_WIDTH  prescaler divide value
cfg_incr  in  ADDR_WIDTH  address step per tick
cfg_bursts  in  BURST_WIDTH  periods per run, 0 = continuous
start  in  1  begin run (honoured in IDLE only)
stop  in  1  request graceful stop at next period boundary
cnt_count  in  ADDR_WIDTH  current value of the address counter
cnt_rst  out  1  synchronous clear to the address counter
cnt_en  out  1  step enable to the address counter
cnt_incr  out  ADDR_WIDTH  step value to the address counter
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a run ends

Behaviour:
- Reset: state IDLE; act_div=0, act_incr=1, act_bursts=0; pending config empty; prescaler=0; period count=0; stop_pend=0.
- Output values during and after reset: cnt_en=0, cnt_rst=0, done=0, busy=0, cnt_incr=1, cfg_ready=1.
- Reset mid-run aborts immediately to these values. No done pulse.
- FSM states: IDLE, CLEAR, RUN, FINISH.
- IDLE:
  - cfg_ready=1. A handshake (cfg_valid & cfg_ready) writes the active registers directly.
  - start -> CLEAR. If cfg and start arrive in the same cycle, the new config is used for that run.
  - stop is ignored.
- CLEAR (exactly 1 cycle):
  - cnt_rst=1, cnt_en=0.
  - Prescaler, period count and stop_pend cleared; stop is still sampled into stop_pend.
  - -> RUN.
- RUN, prescaler:
  - Counts 0..act_div.
  - tick = (prescaler==act_div). On tick: cnt_en=1 for that cycle and prescaler -> 0.
  - act_div=0 gives cnt_en=1 every cycle.
- RUN, wrap detection:
  - wrap = tick & carry-out of the (ADDR_WIDTH+1)-bit sum cnt_count+act_incr.
  - The counter wraps modulo 2^ADDR_WIDTH.
- RUN, on wrap:
  - period count increments.
  - finish = stop_pend | (act_bursts!=0 & period count == act_bursts-1). finish -> FINISH.
  - Any pending config moves to the active registers and resets the period count to 0.
  - If finish and a pending apply coincide, finish takes precedence for this run, but the pending config is still moved to active.
- RUN, configuration and stop:
  - cfg_ready = !pend_valid. A handshake in RUN fills the single-entry pending shadow.
  - stop sets stop_pend; stop is sticky until FINISH.
  - start is ignored.
- FINISH (1 cycle): done=1, cnt_en=0 -> IDLE. The counter is not cleared and holds its last value.
- cnt_en is never asserted outside RUN. cnt_rst is never asserted outside CLEAR.
- Latency:
  - start to cnt_rst: 1 cycle.
  - First cnt_en: 2+act_div cycles after start.
  - Wrap to done: 1 cycle.

Decomposition:
- Package siggen_pkg holds:
  - state enum seq_state_t {IDLE, CLEAR, RUN, FINISH};
  - cfg struct seq_cfg_t {div, incr, bursts};
  - default constants DEF_DIV=0, DEF_INCR=1, DEF_BURSTS=0.
- One natural sub-module: siggen_prescaler (DIV_WIDTH counter with clear, load of div, and tick output).
- FSM, shadow registers and wrap logic stay in the top.

Test Plan:
- Reset, then idle: cfg_ready=1, busy=0, cnt_en=0, cnt_rst=0, cnt_incr=1. No output activity for 20 cycles.
- Burst, with a counter model attached: cfg div=0, incr=64, bursts=2, then start.
  - cnt_rst in cycle 1.
  - cnt_en high for 16 consecutive cycles.
  - done pulse 1 cycle after the 16th tick.
  - busy low the cycle after done.
- Prescaler: div=3, incr=128, bursts=1 -> cnt_en every 4th cycle, 4 ticks total, done after the 4th tick.
- Mid-run config, continuous mode:
  - Run with incr=1. In RUN offer incr=256: accepted, cfg_ready drops.
  - cnt_incr stays 1 until the counter wraps 511->0, then becomes 256 and cfg_ready returns to 1.
  - A second offer before that boundary is stalled (cfg_ready=0).
- Stop: continuous run with incr=64, stop pulsed at count=128 -> ticks continue to the 448->0 wrap, then done. start during RUN is ignored.
- Reset mid-RUN at count=200 -> next cycle busy=0, cnt_en=0, done=0, and the active config returns to the default values.
